inst_encoder: RTL and testbench

//   Inverse of the core's control decoder. Accepts symbolic instruction commands (op index + register/immediate fields)

---
 rtl/inst_encoder.sv | 198 +++++++++++++++++++
 tb/tb_inst_encoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - symbolic command to MIPS-I instruction word encoder with output FIFO
// Define INST_ENCODER_PSEUDO_EN to expand op 42 (li) into a lui/ori pair.
module inst_encoder #(
   parameter int ADDR_W     = 10,
   parameter int BASE_ADDR  = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [31:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_word,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err,
   input  logic              err_clr
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
   localparam logic [PW+1:0]     DEPTH_C = (PW+2)'(FIFO_DEPTH);
   localparam logic [5:0]        OP_LI   = 6'd42;

   logic [31:0]       enc_word;
   logic              enc_legal;
   logic [25:0]       r_alu;
   logic [25:0]       i_fld;
   logic              accept;
   logic              push;
   logic              pop;
   logic              run_q;
   logic              expanding;
   logic [31:0]       expand_word;
   logic              stage_valid;
   logic [31:0]       stage_word;
   logic [PW:0]       count;
   logic [PW+1:0]     used;
   logic [PW+1:0]     need;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [ADDR_W-1:0] addr_cnt;
   logic [ADDR_W-1:0] last_addr;
   logic [31:0]       last_word;
   logic [31:0]       mem_word [FIFO_DEPTH];
   logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];

   assign r_alu = {6'd0, in_rs, in_rt, in_rd, 5'd0};
   assign i_fld = {in_rs, in_rt, in_imm[15:0]};

   always_comb begin
      enc_word  = '0;
      enc_legal = 1'b1;
      case (in_op)
         6'd0:  enc_word = {11'd0, in_rt, in_rd, in_shamt, 6'h00};
         6'd1:  enc_word = {11'd0, in_rt, in_rd, in_shamt, 6'h02};
         6'd2:  enc_word = {11'd0, in_rt, in_rd, in_shamt, 6'h03};
         6'd3:  enc_word = {r_alu, 6'h04};
         6'd4:  enc_word = {r_alu, 6'h06};
         6'd5:  enc_word = {r_alu, 6'h07};
         6'd6:  enc_word = {6'd0, in_rs, 15'd0, 6'h08};
         6'd7:  enc_word = 32'h0000_000C;
         6'd8:  enc_word = {r_alu, 6'h20};
         6'd9:  enc_word = {r_alu, 6'h21};
         6'd10: enc_word = {r_alu, 6'h22};
         6'd11: enc_word = {r_alu, 6'h23};
         6'd12: enc_word = {r_alu, 6'h24};
         6'd13: enc_word = {r_alu, 6'h25};
         6'd14: enc_word = {r_alu, 6'h26};
         6'd15: enc_word = {r_alu, 6'h27};
         6'd16: enc_word = {r_alu, 6'h2A};
         6'd17: enc_word = {r_alu, 6'h2B};
         6'd18: enc_word = {6'h01, in_rs, 5'd0, in_imm[15:0]};
         6'd19: enc_word = {6'h01, in_rs, 5'd1, in_imm[15:0]};
         6'd20: enc_word = {6'h02, in_target};
         6'd21: enc_word = {6'h03, in_target};
         6'd22: enc_word = {6'h04, i_fld};
         6'd23: enc_word = {6'h05, i_fld};
         6'd24: enc_word = {6'h06, in_rs, 5'd0, in_imm[15:0]};
         6'd25: enc_word = {6'h07, in_rs, 5'd0, in_imm[15:0]};
         6'd26: enc_word = {6'h08, i_fld};
         6'd27: enc_word = {6'h09, i_fld};
         6'd28: enc_word = {6'h0A, i_fld};
         6'd29: enc_word = {6'h0B, i_fld};
         6'd30: enc_word = {6'h0C, i_fld};
         6'd31: enc_word = {6'h0D, i_fld};
         6'd32: enc_word = {6'h0E, i_fld};
         6'd33: enc_word = {6'h0F, 5'd0, in_rt, in_imm[15:0]};
         6'd34: enc_word = {6'h20, i_fld};
         6'd35: enc_word = {6'h21, i_fld};
         6'd36: enc_word = {6'h23, i_fld};
         6'd37: enc_word = {6'h24, i_fld};
         6'd38: enc_word = {6'h25, i_fld};
         6'd39: enc_word = {6'h28, i_fld};
         6'd40: enc_word = {6'h29, i_fld};
         6'd41: enc_word = {6'h2B, i_fld};
`ifdef INST_ENCODER_PSEUDO_EN
         6'd42: enc_word = {6'h0F, 5'd0, in_rt, in_imm[31:16]};
`endif
         default: enc_legal = 1'b0;
      endcase
   end

   // Free-slot test uses registered occupancy plus the word parked in the encode stage.
   assign used     = {1'b0, count} + {{(PW+1){1'b0}}, stage_valid};
   assign need     = (in_op == OP_LI) ? (PW+2)'(2) : (PW+2)'(1);
   assign in_ready = run_q && !expanding && ((used + need) <= DEPTH_C);
   assign accept   = in_valid && in_ready;
   assign push     = stage_valid;
   assign out_valid = (count != '0);
   assign pop      = out_valid && out_ready;

`ifdef INST_ENCODER_PSEUDO_EN
   typedef enum logic {IDLE, EXPAND} state_t;
   state_t state, state_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && in_op == OP_LI) state_nxt = EXPAND;
         EXPAND:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign expanding = (state == EXPAND);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      expand_word <= '0;
      else if (accept) expand_word <= {6'h0D, in_rt, in_rt, in_imm[15:0]};
   end
`else
   logic unused_imm_hi;
   assign unused_imm_hi = ^in_imm[31:16];
   assign expanding     = 1'b0;
   assign expand_word   = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q       <= 1'b0;
         stage_valid <= 1'b0;
         stage_word  <= '0;
         err         <= 1'b0;
      end else begin
         run_q       <= 1'b1;
         stage_valid <= expanding || (accept && enc_legal);
         if (expanding)   stage_word <= expand_word;
         else if (accept) stage_word <= enc_word;
         if (accept && !enc_legal) err <= 1'b1;
         else if (err_clr)         err <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_word[wr_ptr] <= stage_word;
         mem_addr[wr_ptr] <= addr_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         addr_cnt  <= BASE;
         last_word <= '0;
         last_addr <= '0;
      end else begin
         count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
         if (push) begin
            wr_ptr   <= wr_ptr + 1'b1;
            addr_cnt <= addr_cnt + 1'b1;
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            last_word <= mem_word[rd_ptr];
            last_addr <= mem_addr[rd_ptr];
         end
      end
   end

   // With the FIFO empty the outputs keep showing the last word that was popped.
   assign out_word = out_valid ? mem_word[rd_ptr] : last_word;
   assign out_addr = out_valid ? mem_addr[rd_ptr] : last_addr;
endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - randomized self-checking bench for inst_encoder
module tb_inst_encoder;
   localparam int AW    = 2;
   localparam int BASE  = 1;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready;
   logic [5:0]    in_op;
   logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
   logic [31:0]   in_imm;
   logic [25:0]   in_target;
   logic          out_valid, out_ready;
   logic [31:0]   out_word;
   logic [AW-1:0] out_addr;
   logic          err, err_clr;

   inst_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
      .in_target(in_target), .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
      .out_addr(out_addr), .err(err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_w[$];
   logic [31:0] exp_a[$];
   logic [31:0] last_w, last_a;
   int  model_addr = BASE;
   bit  model_err  = 1'b0;
   bit  rand_rdy   = 1'b0;

   int fn_tab [0:17]  = '{0, 2, 3, 4, 6, 7, 8, 12, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
   int op_tab [18:41] = '{1, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                          32, 33, 35, 36, 37, 40, 41, 43};

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(int op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                            logic [4:0] sh, logic [31:0] imm, logic [25:0] tgt);
      int opcode;
      if (op <= 17) begin
         if (op <= 2) rs = 0; else sh = 0;
         if (op == 6) begin rt = 0; rd = 0; end
         if (op == 7) begin rs = 0; rt = 0; rd = 0; end
         return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn_tab[op]);
      end
      opcode = op_tab[op];
      if (op == 20 || op == 21) return (32'(opcode) << 26) | 32'(tgt);
      if (op == 18 || op == 24 || op == 25) rt = 0;
      if (op == 19) rt = 1;
      if (op == 33) rs = 0;
      return (32'(opcode) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm[15:0]);
   endfunction

   task automatic expect_word(logic [31:0] w);
      exp_w.push_back(w);
      exp_a.push_back(32'(model_addr));
      model_addr = (model_addr + 1) % (1 << AW);
   endtask

   task automatic send(int op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [4:0] sh,
                       logic [31:0] imm, logic [25:0] tgt, bit eclr);
      int n = 0;
      bit legal = 1'b1;
      in_valid = 1'b1; in_op = 6'(op); in_rs = rs; in_rt = rt; in_rd = rd;
      in_shamt = sh; in_imm = imm; in_target = tgt; err_clr = eclr;
      @(negedge clk);
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      if (!in_ready) begin
         check("accept_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0; err_clr = 1'b0;
         return;
      end
      if (op <= 41) expect_word(ref_word(op, rs, rt, rd, sh, imm, tgt));
`ifdef INST_ENCODER_PSEUDO_EN
      else if (op == 42) begin
         expect_word(ref_word(33, 0, rt, 0, 0, imm >> 16, 0));
         expect_word(ref_word(31, rt, rt, 0, 0, imm, 0));
      end
`endif
      else legal = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; err_clr = 1'b0;
      model_err = legal ? (eclr ? 1'b0 : model_err) : 1'b1;
      check("err", 32'(err), 32'(model_err));
   endtask

   task automatic kat(int back, logic [31:0] w);
      exp_w[exp_w.size() - 1 - back] = w;
   endtask

   task automatic clr_err();
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      model_err = 1'b0;
      check("err_clr", 32'(err), 32'd0);
   endtask

   task automatic drain();
      int n = 0;
      rand_rdy = 1'b0;
      out_ready = 1'b1;
      while (exp_w.size() != 0 && n < 300) begin @(negedge clk); n++; end
      check("drain_left", 32'(exp_w.size()), 32'd0);
      @(posedge clk); #1;
      check("empty_valid", 32'(out_valid), 32'd0);
      check("hold_word", out_word, last_w);
      check("hold_addr", 32'(out_addr), last_a);
   endtask

   task automatic send_rand(bit eclr);
      send(int'($urandom_range(0, 41)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           $urandom, 26'($urandom), eclr);
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_w.size() == 0) check("spurious_pop", 32'(out_valid), 32'd0);
         else begin
            last_w = exp_w.pop_front();
            last_a = exp_a.pop_front();
            check("word", out_word, last_w);
            check("addr", 32'(out_addr), last_a);
         end
      end
   end

   initial forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required $finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
      in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0; in_target = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("ready_after_rst", 32'(in_ready), 32'd1);

      out_ready = 1'b1;
      send(9, 1, 2, 3, 0, 0, 0, 0);           kat(0, 32'h0022_1821);
      check("latency", 32'(out_valid), 32'd0);
      send(36, 29, 8, 0, 0, 32'hFFFC, 0, 0);  kat(0, 32'h8FA8_FFFC);
      send(19, 5, 0, 0, 0, 3, 0, 0);          kat(0, 32'h04A1_0003);
      send(20, 0, 0, 0, 0, 0, 26'h0100000, 0); kat(0, 32'h0810_0000);
      send(6, 31, 0, 7, 5, 0, 0, 0);          kat(0, 32'h03E0_0008);
      send(7, 9, 10, 11, 12, 32'h1234, 0, 0); kat(0, 32'h0000_000C);
      drain();

      send(50, 1, 2, 3, 4, 5, 6, 0);
      send(13, 4, 5, 6, 0, 0, 0, 0);
      clr_err();
      send(50, 0, 0, 0, 0, 0, 0, 1);
      clr_err();
      drain();

      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) send_rand(0);
      in_valid = 1'b1; in_op = 6'd9;
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      send_rand(0);
      drain();

`ifdef INST_ENCODER_PSEUDO_EN
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) send_rand(0);
      in_valid = 1'b1; in_op = 6'd42;
      @(negedge clk);
      check("li_needs_two", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      send(42, 0, 4, 0, 0, 32'h1234_5678, 0, 0);
      kat(1, 32'h3C04_1234);
      kat(0, 32'h3484_5678);
      drain();
`else
      send(42, 0, 4, 0, 0, 32'h1234_5678, 0, 0);
      clr_err();
      drain();
`endif

      rand_rdy = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0)
            send(int'($urandom_range(42, 63)), 5'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), $urandom, 26'($urandom), 1'($urandom_range(0, 1)));
         else
            send_rand(1'($urandom_range(0, 9) == 0));
      end
      drain();

      out_ready = 1'b0;
      send_rand(0);
      send_rand(0);
      send(50, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #2;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_err", 32'(err), 32'd0);
      exp_w.delete();
      exp_a.delete();
      model_addr = BASE;
      model_err = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(9, 1, 2, 3, 0, 0, 0, 0);
      drain();
      check("post_rst_addr", 32'(out_addr), 32'(BASE));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
